// File: rtl/seven_segment_decoder.sv
// Recovers the 32-bit hex word from the active-low anode/cathode lines of a multiplexed 8-digit display.
// Optional build macro SEVEN_SEG_DECODER_ERRCNT_EN adds the saturating err_count_out counter.
module seven_segment_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  an_in,
  input  logic [6:0]  cat_in,
  output logic [31:0] val_out,
  output logic        valid_out,
  output logic        frame_out,
  output logic        err_out
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
  ,
  output logic [15:0] err_count_out
`endif
);

  localparam logic [15:0] SETTLE_MAX  = 16'(SETTLE_CYCLES);
  localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } glyph_t;

  function automatic glyph_t decode_glyph(input logic [6:0] seg);
    glyph_t g;
    g.ok  = 1'b1;
    g.nib = 4'h0;
    case (seg)
      7'h3F: g.nib = 4'h0;
      7'h06: g.nib = 4'h1;
      7'h5B: g.nib = 4'h2;
      7'h4F: g.nib = 4'h3;
      7'h66: g.nib = 4'h4;
      7'h6D: g.nib = 4'h5;
      7'h7D: g.nib = 4'h6;
      7'h07: g.nib = 4'h7;
      7'h7F: g.nib = 4'h8;
      7'h6F: g.nib = 4'h9;
      7'h77: g.nib = 4'hA;
      7'h7C: g.nib = 4'hB;
      7'h39: g.nib = 4'hC;
      7'h5E: g.nib = 4'hD;
      7'h79: g.nib = 4'hE;
      7'h71: g.nib = 4'hF;
      default: g.ok = 1'b0;
    endcase
    return g;
  endfunction

  // Two-flop input stage; the board lines are asynchronous to clk_in.
  logic [7:0]  an_q1, an_q2;
  logic [6:0]  cat_q1, cat_q2;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [14:0] pair, pair_prev;
  logic        pair_same;
  logic        an_onehot;
  glyph_t      glyph;

  logic [15:0] settle_cnt, settle_next;
  logic [31:0] idle_cnt, idle_next;
  logic        capture, cap_fire, cap_ok, cap_err;
  logic        frame_done, timeout_hit;

  logic [31:0] shadow, shadow_next;
  logic [7:0]  seen, seen_next;
  logic        cap_err_q, cap_done_q;

  assign an        = ~an_q2;
  assign seg       = ~cat_q2;
  assign pair      = {an, seg};
  assign pair_same = (pair == pair_prev);
  assign an_onehot = (an != 8'h00) && ((an & (an - 8'h01)) == 8'h00);
  assign glyph     = decode_glyph(seg);

  // NOTE: every variable gets its default first so no path through the block infers a latch.
  always_comb begin
    settle_next = 16'd1;
    if (pair_same) begin
      settle_next = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + 16'd1;
    end
    // Fires only on the transition into saturation: one capture per dwell.
    capture  = (settle_next == SETTLE_MAX) && (settle_cnt != SETTLE_MAX);
    cap_fire = capture && an_onehot;
    cap_ok   = cap_fire && glyph.ok;
    cap_err  = cap_fire && !glyph.ok;

    idle_next = cap_fire ? 32'd0
              : (idle_cnt == TIMEOUT_MAX) ? idle_cnt : idle_cnt + 32'd1;
    timeout_hit = !cap_fire && (idle_cnt >= TIMEOUT_MAX - 32'd1);
  end

  always_comb begin
    shadow_next = shadow;
    seen_next   = seen;
    frame_done  = 1'b0;
    if (cap_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (an[i]) shadow_next[4*i +: 4] = glyph.nib;
      end
      seen_next  = seen | an;
      frame_done = (seen_next == 8'hFF);
      if (frame_done) seen_next = 8'h00;
    end else if (timeout_hit) begin
      seen_next = 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      an_q1      <= 8'h00;
      an_q2      <= 8'h00;
      cat_q1     <= 7'h00;
      cat_q2     <= 7'h00;
      pair_prev  <= 15'h0000;
      settle_cnt <= 16'd0;
      idle_cnt   <= 32'd0;
    end else begin
      an_q1      <= an_in;
      an_q2      <= an_q1;
      cat_q1     <= cat_in;
      cat_q2     <= cat_q1;
      pair_prev  <= pair;
      settle_cnt <= settle_next;
      idle_cnt   <= idle_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shadow     <= 32'h0;
      seen       <= 8'h00;
      cap_err_q  <= 1'b0;
      cap_done_q <= 1'b0;
    end else begin
      shadow     <= shadow_next;
      seen       <= seen_next;
      cap_err_q  <= cap_err;
      cap_done_q <= frame_done;
    end
  end

  // Published word changes only here, one edge after the completing capture.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_out   <= 32'h0;
      valid_out <= 1'b0;
      frame_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      frame_out <= cap_done_q;
      err_out   <= cap_err_q;
      if (cap_done_q) begin
        val_out   <= shadow;
        valid_out <= 1'b1;
      end else if (timeout_hit) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      err_count_out <= 16'h0000;
    end else if (cap_err_q && (err_count_out != 16'hFFFF)) begin
      err_count_out <= err_count_out + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Randomized scoreboard bench for seven_segment_decoder: a dwell-level display model predicts frames and errors.
module tb_seven_segment_decoder;

  localparam int S = 16;
  localparam int T = 500;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  an_in;
  logic [6:0]  cat_in;
  logic [31:0] val_out;
  logic        valid_out, frame_out, err_out;
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
  logic [15:0] err_count_out;
`endif

  always #5 clk_in = ~clk_in;

  seven_segment_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .an_in    (an_in),
    .cat_in   (cat_in),
    .val_out  (val_out),
    .valid_out(valid_out),
    .frame_out(frame_out),
    .err_out  (err_out)
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    ,
    .err_count_out(err_count_out)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: tracks how long the displayed pair has been held and applies the capture rules.
  logic [31:0] exp_q[$];
  logic [31:0] m_shadow, m_last_word;
  logic [7:0]  m_seen;
  logic [14:0] m_pair;
  logic        m_valid;
  int          m_run, m_idle, m_err_exp;

  function automatic int glyph_value(input logic [6:0] s);
    for (int v = 0; v < 16; v++) begin
      if (GLYPH[v] == s) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_shadow    = 32'h0;
    m_last_word = 32'h0;
    m_seen      = 8'h00;
    m_pair      = 15'h7FFF;
    m_valid     = 1'b0;
    m_run       = 0;
    m_idle      = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [7:0] an_pins, input logic [6:0] cat_pins);
    logic [7:0]  a = ~an_pins;
    logic [6:0]  s = ~cat_pins;
    logic [14:0] p = {a, s};
    bit          fired = 1'b0;
    int          gv, idx;
    if (p == m_pair) begin
      fired = (m_run == S - 1);
      if (m_run < S) m_run++;
    end else begin
      m_pair = p;
      m_run  = 1;
    end
    if (fired && $countones(a) == 1) begin
      m_idle = 0;
      gv = glyph_value(s);
      if (gv < 0) begin
        m_err_exp++;
      end else begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (a[i]) idx = i;
        m_shadow[4*idx +: 4] = 4'(gv);
        m_seen = m_seen | a;
        if (m_seen == 8'hFF) begin
          exp_q.push_back(m_shadow);
          m_last_word = m_shadow;
          m_valid = 1'b1;
          m_seen  = 8'h00;
        end
      end
    end else begin
      m_idle++;
      if (m_idle >= T) begin
        m_seen  = 8'h00;
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: pops expectations on frame_out and tallies observed events.
  int          cyc = 0, frames = 0, err_seen = 0, atomic_bad = 0;
  int          frame_cyc = 0, fall_cyc = 0, lat_start = 0;
  logic [31:0] val_prev = 32'h0;
  logic        valid_prev = 1'b0;

  always @(negedge clk_in) begin
    cyc++;
    if (frame_out) begin
      frames++;
      frame_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got %h, expected no frame", val_out);
      end else begin
        check("frame_val", val_out, exp_q.pop_front());
        check("frame_valid", 32'(valid_out), 32'd1);
      end
    end
    if (err_out) err_seen++;
    if (!rst_in && !frame_out && val_out !== val_prev) atomic_bad++;
    if (valid_prev && !valid_out) fall_cyc = cyc;
    val_prev   = val_out;
    valid_prev = valid_out;
  end

  // Stimulus helpers; all called at posedge+1.
  task automatic drive(input logic [7:0] an_pins, input logic [6:0] cat_pins, input int n);
    an_in  = an_pins;
    cat_in = cat_pins;
    repeat (n) begin
      model_step(an_pins, cat_pins);
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic flush(input int n);
    drive(8'hFF, 7'h7F, n);
  endtask

  task automatic scan(input logic [31:0] word, input int dwell, input bit ghost,
                      input int first, input int last);
    logic [6:0] prev_cat;
    logic [7:0] an_p;
    logic [6:0] cat_p;
    logic [3:0] nib;
    prev_cat = cat_in;
    for (int d = first; d <= last; d++) begin
      an_p  = ~(8'h01 << d);
      nib   = word[4*d +: 4];
      cat_p = ~GLYPH[nib];
      if (ghost) drive(an_p, prev_cat, 2);
      if (d == 7) lat_start = cyc + 1;
      drive(an_p, cat_p, dwell);
      prev_cat = cat_p;
    end
  endtask

  task automatic random_event();
    logic [7:0] a;
    case ($urandom_range(0, 2))
      0: drive(~(8'h01 << $urandom_range(0, 7)), 7'h7F, $urandom_range(S, 30));
      1: begin
        do a = 8'($urandom); while ($countones(~a) == 1);
        drive(a, 7'($urandom), $urandom_range(S, 40));
      end
      default: drive(8'($urandom), 7'($urandom), $urandom_range(1, S - 1));
    endcase
  endtask

  int f0, e0, err_at_reset, sp;
  logic [31:0] w;

  initial begin
    rst_in    = 1'b1;
    an_in     = 8'hFF;
    cat_in    = 7'h7F;
    m_err_exp = 0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_val", val_out, 32'h0);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_frame", 32'(frame_out), 32'd0);
    check("reset_err", 32'(err_out), 32'd0);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Steady display of DEADBEEF: two scans, one frame each, no errors, fixed latency.
    f0 = frames; e0 = err_seen;
    scan(32'hDEADBEEF, 40, 1'b0, 0, 7);
    check("latency_frame", 32'(frame_cyc - lat_start), 32'(S + 3));
    scan(32'hDEADBEEF, 40, 1'b1, 0, 7);
    flush(8);
    check("scan_frames", 32'(frames - f0), 32'd2);
    check("scan_val", val_out, 32'hDEADBEEF);
    check("scan_valid", 32'(valid_out), 32'd1);
    check("scan_no_err", 32'(err_seen - e0), 32'd0);

    // Value changes at a scan boundary: each frame carries one whole word.
    scan(32'hDEADBEEF, 40, 1'b1, 0, 7);
    check("switch_old", val_out, 32'hDEADBEEF);
    scan(32'h01234567, 40, 1'b1, 0, 7);
    flush(8);
    check("switch_new", val_out, 32'h01234567);

    // 10-cycle hold of digit 2 is ignored; frame needs digit 2 later.
    f0 = frames; e0 = err_seen;
    drive(~8'h04, ~7'h06, 10);
    drive(~8'h20, ~GLYPH[3], 40);
    scan(32'h89ABCDEF, 40, 1'b0, 0, 1);
    scan(32'h89ABCDEF, 40, 1'b0, 3, 7);
    flush(8);
    check("short_no_err", 32'(err_seen - e0), 32'd0);
    check("short_no_frame", 32'(frames - f0), 32'd0);
    scan(32'h89ABCDEF, 40, 1'b0, 2, 2);
    flush(8);
    check("short_then_frame", 32'(frames - f0), 32'd1);
    check("short_frame_val", val_out, 32'h89ABCDEF);

    // Blank glyph held 32 cycles: exactly one error, no frame.
    f0 = frames; e0 = err_seen;
    drive(8'hFE, 7'h7F, 32);
    flush(8);
    check("blank_err", 32'(err_seen - e0), 32'd1);
    check("blank_no_frame", 32'(frames - f0), 32'd0);
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    check("errcnt_one", 32'(err_count_out), 32'd1);
`endif

    // Two anodes: ignored. Then driver stops after a frame: valid_out times out.
    f0 = frames; e0 = err_seen;
    drive(8'hFC, ~GLYPH[5], 100);
    check("multi_no_err", 32'(err_seen - e0), 32'd0);
    check("multi_no_frame", 32'(frames - f0), 32'd0);
    scan(32'hA5C30F96, 40, 1'b1, 0, 7);
    flush(T + 100);
    check("timeout_delay", 32'(fall_cyc - frame_cyc), 32'(T - 1));
    check("timeout_valid", 32'(valid_out), 32'd0);
    check("timeout_val_kept", val_out, 32'hA5C30F96);

    // Async reset after 5 of 8 digits.
    scan(32'h13579BDF, 40, 1'b0, 0, 7);
    scan(32'h2468ACE0, 40, 1'b0, 0, 4);
    check("pre_reset_valid", 32'(valid_out), 32'd1);
    an_in  = 8'hFF;
    cat_in = 7'h7F;
    #2 rst_in = 1'b1;
    #1;
    check("async_reset_val", val_out, 32'h0);
    check("async_reset_valid", 32'(valid_out), 32'd0);
    model_reset();
    err_at_reset = err_seen;
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    f0 = frames;
    scan(32'h2468ACE0, 40, 1'b0, 5, 7);
    flush(8);
    check("reset_partial_no_frame", 32'(frames - f0), 32'd0);
    scan(32'h2468ACE0, 40, 1'b1, 0, 7);
    flush(8);
    check("reset_full_frame", 32'(frames - f0), 32'd1);
    check("reset_full_val", val_out, 32'h2468ACE0);

    // Randomized scans with ghosting, glitches, blanks and multi-anode holds.
    for (int r = 0; r < 30; r++) begin
      w  = $urandom;
      sp = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) random_event();
      scan(w, $urandom_range(S, 40), 1'($urandom_range(0, 1)), 0, sp);
      if (sp < 7) begin
        if ($urandom_range(0, 2) == 0) random_event();
        scan(w, $urandom_range(S, 40), 1'($urandom_range(0, 1)), sp + 1, 7);
      end
    end
    flush(S + 10);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_err_total", 32'(err_seen), 32'(m_err_exp));
    check("final_val", val_out, m_last_word);
    check("final_valid", 32'(valid_out), 32'(m_valid));
    check("val_atomic", 32'(atomic_bad), 32'd0);
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    check("errcnt_final", 32'(err_count_out), 32'(err_seen - err_at_reset));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
